// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) types, bit-position constants and helper functions.
// Codeword positions run 7..1 with parity at 1/2/4 and data at 3/5/6/7.
package hamming_pkg;

    typedef logic [7:1] code_t;
    typedef logic [3:0] data_t;
    typedef logic [2:0] synd_t;

    localparam int P1_POS = 1;
    localparam int P2_POS = 2;
    localparam int P4_POS = 4;
    localparam int D0_POS = 3;
    localparam int D1_POS = 5;
    localparam int D2_POS = 6;
    localparam int D3_POS = 7;

    // Each syndrome bit re-checks one parity group; the result names the bad position.
    function automatic synd_t calc_syndrome(input code_t c);
        synd_t s;
        s[0] = c[P1_POS] ^ c[D0_POS] ^ c[D1_POS] ^ c[D3_POS];
        s[1] = c[P2_POS] ^ c[D0_POS] ^ c[D2_POS] ^ c[D3_POS];
        s[2] = c[P4_POS] ^ c[D1_POS] ^ c[D2_POS] ^ c[D3_POS];
        return s;
    endfunction

    function automatic data_t extract_data(input code_t c);
        return {c[D3_POS], c[D2_POS], c[D1_POS], c[D0_POS]};
    endfunction

endpackage

// File: rtl/hamming_74_correct.sv
// Combinational single-bit corrector: flips the bit named by the syndrome and
// extracts the data nibble. The syndrome arrives precomputed from stage 1.
module hamming_74_correct
    import hamming_pkg::*;
(
    input  code_t code,
    input  synd_t synd,
    output data_t data,
    output logic  corrected
);

    code_t fixed;

    always_comb begin
        fixed = code;
        for (int i = 1; i <= 7; i++) begin
            if (synd == synd_t'(i)) begin
                fixed[i] = ~code[i];
            end
        end
    end

    assign data      = extract_data(fixed);
    assign corrected = (synd != '0);

endmodule

// File: rtl/hamming_74_decoder_pipe.sv
// Two-stage Hamming(7,4) decoder: stage 1 captures code + syndrome, stage 2
// corrects and presents data. Saturating word / corrected counters on delivery.
module hamming_74_decoder_pipe
    import hamming_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:1]       in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_data,
    output logic [2:0]       out_syndrome,
    output logic             out_corrected,
    input  logic             clr_counts,
    output logic [CNT_W-1:0] word_count,
    output logic [CNT_W-1:0] corr_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Handshakes: a transfer happens on a rising clk edge where valid && ready;
    // valid never waits on ready, and a stalled stage holds its contents.
    logic  v1, v2;
    code_t code1;
    synd_t synd1;
    data_t data2;
    synd_t synd2;
    logic  corr2;
    logic  adv1, adv2, in_fire, out_fire;
    data_t data_c;
    logic  corr_c;

    assign adv2     = !v2 || out_ready;
    assign adv1     = v1 && adv2;
    assign in_ready = !v1 || adv2;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = v2 && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            code1 <= '0;
            synd1 <= '0;
        end else if (in_fire) begin
            v1    <= 1'b1;
            code1 <= in_code;
            synd1 <= calc_syndrome(in_code);
        end else if (adv1) begin
            v1    <= 1'b0;
        end
    end

    hamming_74_correct u_correct (
        .code      (code1),
        .synd      (synd1),
        .data      (data_c),
        .corrected (corr_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2    <= 1'b0;
            data2 <= '0;
            synd2 <= '0;
            corr2 <= 1'b0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                data2 <= data_c;
                synd2 <= synd1;
                corr2 <= corr_c;
            end
        end
    end

    assign out_valid     = v2;
    assign out_data      = data2;
    assign out_syndrome  = synd2;
    assign out_corrected = corr2;

    // Clear takes priority over a coincident delivery.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_count <= '0;
            corr_count <= '0;
        end else if (clr_counts) begin
            word_count <= '0;
            corr_count <= '0;
        end else if (out_fire) begin
            if (word_count != CNT_MAX) word_count <= word_count + CNT_W'(1);
            if (corr2 && corr_count != CNT_MAX) corr_count <= corr_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hamming_74_decoder_pipe.sv
// Bench for the Hamming(7,4) decoder pipe: a wide-counter and a 4-bit-counter
// instance share one stimulus stream and are checked against a nearest-codeword model.
module tb_hamming_74_decoder_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:1] in_code = '0;
    logic       out_ready = 1'b0;
    logic       clr_counts = 1'b0;

    logic        in_ready, out_valid, out_corrected;
    logic [3:0]  out_data;
    logic [2:0]  out_syndrome;
    logic [15:0] word_count, corr_count;

    logic        n_in_ready, n_out_valid, n_out_corrected;
    logic [3:0]  n_out_data;
    logic [2:0]  n_out_syndrome;
    logic [3:0]  n_word_count, n_corr_count;

    hamming_74_decoder_pipe #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_code(in_code), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_syndrome(out_syndrome), .out_corrected(out_corrected),
        .clr_counts(clr_counts), .word_count(word_count), .corr_count(corr_count)
    );

    hamming_74_decoder_pipe #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(n_in_ready),
        .in_code(in_code), .out_valid(n_out_valid), .out_ready(out_ready),
        .out_data(n_out_data), .out_syndrome(n_out_syndrome), .out_corrected(n_out_corrected),
        .clr_counts(clr_counts), .word_count(n_word_count), .corr_count(n_corr_count)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int         n_checks = 0;
    int         n_err = 0;
    int         cyc = 0;
    logic [6:0] exp_q[$];
    int         t_q[$];
    logic [3:0] got_d_q[$];
    logic [2:0] got_s_q[$];
    int         m_wc = 0;
    int         m_cc = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Codeword as a 7-bit vector where bit i-1 holds position i.
    function automatic logic [6:0] encode(input logic [3:0] d);
        logic [6:0] c;
        c = '0;
        c[2] = d[0]; c[4] = d[1]; c[5] = d[2]; c[6] = d[3];
        c[0] = d[0] ^ d[1] ^ d[3];
        c[1] = d[0] ^ d[2] ^ d[3];
        c[3] = d[1] ^ d[2] ^ d[3];
        return c;
    endfunction

    // Nearest valid codeword search: distance 0 -> clean, distance 1 -> position of the flip.
    task automatic decode(input logic [6:0] c, output logic [3:0] d, output logic [2:0] s);
        d = '0;
        s = '0;
        for (int v = 0; v < 16; v++) begin
            logic [6:0] diff;
            diff = c ^ encode(4'(v));
            if ($countones(diff) <= 1) begin
                d = 4'(v);
                for (int p = 0; p < 7; p++) if (diff[p]) s = 3'(p + 1);
            end
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic       exp_valid, exp_ready;
        logic [3:0] d;
        logic [2:0] s;
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            t_q.delete();
            m_wc = 0;
            m_cc = 0;
        end else begin
            exp_valid = (exp_q.size() > 0) && (t_q[0] + 2 <= cyc);
            exp_ready = (exp_q.size() < 2) || out_ready;
            chk("out_valid", 32'(out_valid), 32'(exp_valid));
            chk("n_out_valid", 32'(n_out_valid), 32'(exp_valid));
            chk("in_ready", 32'(in_ready), 32'(exp_ready));
            chk("n_in_ready", 32'(n_in_ready), 32'(exp_ready));
            d = '0;
            s = '0;
            if (exp_valid) begin
                decode(exp_q[0], d, s);
                chk("out_data", 32'(out_data), 32'(d));
                chk("out_syndrome", 32'(out_syndrome), 32'(s));
                chk("out_corrected", 32'(out_corrected), 32'(s != 0));
                chk("n_out_data", 32'(n_out_data), 32'(d));
            end
            chk("word_count", 32'(word_count), 32'(sat(m_wc, 65535)));
            chk("corr_count", 32'(corr_count), 32'(sat(m_cc, 65535)));
            chk("n_word_count", 32'(n_word_count), 32'(sat(m_wc, 15)));
            chk("n_corr_count", 32'(n_corr_count), 32'(sat(m_cc, 15)));
            if (exp_valid && out_ready) begin
                void'(exp_q.pop_front());
                void'(t_q.pop_front());
                got_d_q.push_back(d);
                got_s_q.push_back(s);
                m_wc++;
                if (s != 0) m_cc++;
            end
            if (clr_counts) begin
                m_wc = 0;
                m_cc = 0;
            end
            if (in_valid && exp_ready) begin
                exp_q.push_back(in_code);
                t_q.push_back(cyc);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [6:0] c);
        in_valid = 1'b1;
        in_code  = c;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        chk("send_timeout", 32'd1, 32'd0);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic pulse_clr();
        clr_counts = 1'b1;
        @(posedge clk);
        #1;
        clr_counts = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data", 32'(out_data), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;

        // Clean words back to back
        got_d_q.delete(); got_s_q.delete();
        send(7'b0000000);
        send(7'b1010101);
        send(7'b1111111);
        drain();
        chk("clean_d0", 32'(got_d_q[0]), 32'h0);
        chk("clean_d1", 32'(got_d_q[1]), 32'hB);
        chk("clean_d2", 32'(got_d_q[2]), 32'hF);
        chk("clean_syn1", 32'(got_s_q[1]), 32'd0);
        chk("clean_wc", 32'(word_count), 32'd3);
        chk("clean_cc", 32'(corr_count), 32'd0);

        // Single-bit errors: data bit 6 and parity bit 1
        got_d_q.delete(); got_s_q.delete();
        send(7'b1110101);
        send(7'b1010100);
        drain();
        chk("err6_data", 32'(got_d_q[0]), 32'hB);
        chk("err6_syn", 32'(got_s_q[0]), 32'd6);
        chk("err1_data", 32'(got_d_q[1]), 32'hB);
        chk("err1_syn", 32'(got_s_q[1]), 32'd1);
        chk("err_cc", 32'(corr_count), 32'd2);
        chk("err_wc", 32'(word_count), 32'd5);

        // Exhaustive 16 data x 8 error positions
        pulse_clr();
        for (int d = 0; d < 16; d++) begin
            for (int e = 0; e < 8; e++) begin
                logic [6:0] c;
                c = encode(4'(d));
                if (e != 0) c[e-1] = ~c[e-1];
                send(c);
            end
        end
        drain();
        chk("sweep_wc", 32'(word_count), 32'd128);
        chk("sweep_cc", 32'(corr_count), 32'd112);
        chk("sweep_n_wc", 32'(n_word_count), 32'd15);
        chk("sweep_n_cc", 32'(n_corr_count), 32'd15);

        // Saturation with 20 corrected words
        pulse_clr();
        for (int i = 0; i < 20; i++) begin
            logic [6:0] c;
            c = encode(4'(i % 16));
            c[i % 7] = ~c[i % 7];
            send(c);
        end
        drain();
        chk("sat_n_wc", 32'(n_word_count), 32'd15);
        chk("sat_n_cc", 32'(n_corr_count), 32'd15);
        chk("sat_wc", 32'(word_count), 32'd20);
        chk("sat_cc", 32'(corr_count), 32'd20);

        // Clear coinciding with a delivery handshake
        out_ready = 1'b0;
        send(7'b1110101);
        @(negedge clk);
        @(posedge clk);
        #1;
        out_ready  = 1'b1;
        clr_counts = 1'b1;
        @(posedge clk);
        #1;
        clr_counts = 1'b0;
        chk("clr_wc", 32'(word_count), 32'd0);
        chk("clr_cc", 32'(corr_count), 32'd0);
        chk("clr_n_wc", 32'(n_word_count), 32'd0);

        // Backpressure: two words buffer, third must wait
        drain();
        out_ready = 1'b0;
        got_d_q.delete(); got_s_q.delete();
        send(encode(4'd3));
        begin
            logic [6:0] c;
            c = encode(4'd9);
            c[1] = ~c[1];
            send(c);
        end
        in_valid = 1'b1;
        in_code  = encode(4'd12);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(encode(4'd12));
        drain();
        chk("bp_count", 32'(got_d_q.size()), 32'd3);
        chk("bp_d0", 32'(got_d_q[0]), 32'd3);
        chk("bp_d1", 32'(got_d_q[1]), 32'd9);
        chk("bp_s1", 32'(got_s_q[1]), 32'd2);
        chk("bp_d2", 32'(got_d_q[2]), 32'd12);

        // Async reset with both stages full
        out_ready = 1'b0;
        send(encode(4'd5));
        send(encode(4'd10));
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_wc", 32'(word_count), 32'd0);
        chk("rst_n_cc", 32'(n_corr_count), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        got_d_q.delete(); got_s_q.delete();
        send(encode(4'd6));
        drain();
        chk("post_rst_count", 32'(got_d_q.size()), 32'd1);
        chk("post_rst_d", 32'(got_d_q[0]), 32'd6);
        chk("post_rst_wc", 32'(word_count), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
